// File: rtl/alu_mul_seq_pkg.sv
// Shared definitions for the multiply sequencer and its ALU.
//   WIDTH      : datapath width shared by the ALU and the sequencer
//   alu_func_e : ALU operation codes
//   state_e    : sequencer state encoding
package alu_mul_seq_pkg;

  localparam int WIDTH = 16;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_INC = 3'b010,
    ALU_SHL = 3'b011,
    ALU_SHR = 3'b100,
    ALU_AND = 3'b101,
    ALU_ORR = 3'b110,
    ALU_NOT = 3'b111
  } alu_func_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_mul_seq_alu.sv
// Shared combinational ALU.
// Ports:
//   func_i : operation code (alu_func_e)
//   a_i    : operand A
//   b_i    : operand B
//   r_o    : result
//   z_o    : result is zero
//   n_o    : result MSB
//   c_o    : carry out (ADD/INC), no-borrow (SUB), shifted-out bit (SHL/SHR),
//            0 for logic ops
module alu_mul_seq_alu
  import alu_mul_seq_pkg::*;
#(
  parameter int WIDTH = alu_mul_seq_pkg::WIDTH
) (
  input  logic [2:0]       func_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] r_o,
  output logic             z_o,
  output logic             n_o,
  output logic             c_o
);

  // One extra bit on top carries c_o for every operation.
  logic [WIDTH:0] res;

  always_comb begin
    res = '0;
    case (alu_func_e'(func_i))
      ALU_ADD: res = {1'b0, a_i} + {1'b0, b_i};
      ALU_SUB: res = {1'b0, a_i} + {1'b0, ~b_i} + (WIDTH+1)'(1);
      ALU_INC: res = {1'b0, a_i} + (WIDTH+1)'(1);
      ALU_SHL: res = {a_i, 1'b0};
      ALU_SHR: res = {a_i[0], 1'b0, a_i[WIDTH-1:1]};
      ALU_AND: res = {1'b0, a_i & b_i};
      ALU_ORR: res = {1'b0, a_i | b_i};
      ALU_NOT: res = {1'b0, ~a_i};
      default: res = '0;
    endcase
  end

  assign r_o = res[WIDTH-1:0];
  assign c_o = res[WIDTH];
  assign z_o = (res[WIDTH-1:0] == '0);
  assign n_o = res[WIDTH-1];

endmodule

// File: rtl/alu_mul_seq.sv
// Multi-cycle unsigned multiplier: shift-add using one ALU ADD per cycle.
// Ports:
//   clk     : clock, rising edge
//   rst     : asynchronous active-high reset
//   start_i : request, honoured only in IDLE or DONE
//   a_i     : multiplicand, captured on accept
//   b_i     : multiplier, captured on accept
//   busy_o  : high while iterating
//   done_o  : one-cycle pulse, product valid
//   hi_o    : product bits [2*WIDTH-1:WIDTH]
//   lo_o    : product bits [WIDTH-1:0]
//   zero_o  : product == 0, updated with done
//   ovf_o   : hi != 0, updated with done
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | waiting for start; results from the last operation held
// ST_RUN  | one shift-add iteration per cycle, ITERS cycles total
// ST_DONE | product valid for one cycle; start here chains a new op
module alu_mul_seq
  import alu_mul_seq_pkg::*;
#(
  parameter int WIDTH = alu_mul_seq_pkg::WIDTH,
  parameter int ITERS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             zero_o,
  output logic             ovf_o
);

  localparam int CNT_W = $clog2(ITERS);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [WIDTH-1:0]   p_hi_q, p_hi_d;
  logic [WIDTH-1:0]   p_lo_q, p_lo_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               zero_q, zero_d;
  logic               ovf_q, ovf_d;

  logic [2:0]         alu_func;
  logic [WIDTH-1:0]   alu_a;
  logic [WIDTH-1:0]   alu_b;
  logic [WIDTH-1:0]   alu_r;
  logic               alu_c;
  logic [1:0]         unused_alu_flags;

  alu_mul_seq_alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .func_i (alu_func),
    .a_i    (alu_a),
    .b_i    (alu_b),
    .r_o    (alu_r),
    .z_o    (unused_alu_flags[0]),
    .n_o    (unused_alu_flags[1]),
    .c_o    (alu_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      m_q     <= '0;
      p_hi_q  <= '0;
      p_lo_q  <= '0;
      cnt_q   <= '0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      p_hi_q  <= p_hi_d;
      p_lo_q  <= p_lo_d;
      cnt_q   <= cnt_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    m_d      = m_q;
    p_hi_d   = p_hi_q;
    p_lo_d   = p_lo_q;
    cnt_d    = cnt_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    alu_func = ALU_ADD;
    alu_a    = '0;
    alu_b    = '0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          m_d     = a_i;
          p_hi_d  = '0;
          p_lo_d  = b_i;
          cnt_d   = '0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RUN: begin
        alu_a  = p_hi_q;
        alu_b  = p_lo_q[0] ? m_q : '0;
        // Shift {carry, sum, P_lo} right by one: the ALU carry becomes the
        // new MSB of P_hi, so no bit of the partial product is ever lost.
        p_hi_d = {alu_c, alu_r[WIDTH-1:1]};
        p_lo_d = {alu_r[0], p_lo_q[WIDTH-1:1]};
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(ITERS - 1)) begin
          state_d = ST_DONE;
          zero_d  = ({p_hi_d, p_lo_d} == '0);
          ovf_d   = (p_hi_d != '0);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign busy_o = (state_q == ST_RUN);
  assign done_o = (state_q == ST_DONE);
  assign hi_o   = p_hi_q;
  assign lo_o   = p_lo_q;
  assign zero_o = zero_q;
  assign ovf_o  = ovf_q;

endmodule

// File: tb/tb_alu_mul_seq.sv
module tb_alu_mul_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] hi;
  logic [15:0] lo;
  logic        zero;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  alu_mul_seq dut (
    .clk     (clk),
    .rst     (rst),
    .start_i (start),
    .a_i     (a),
    .b_i     (b),
    .busy_o  (busy),
    .done_o  (done),
    .hi_o    (hi),
    .lo_o    (lo),
    .zero_o  (zero),
    .ovf_o   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an accepted request occupies the unit for 16 cycles,
  // then the product a*b is presented for exactly one cycle, during which a
  // new request may be accepted again.
  int          run_left = 0;
  bit          exp_done = 1'b0;
  bit          load_pending = 1'b0;
  logic [15:0] load_b = '0;
  logic [31:0] exp_q[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      run_left     <= 0;
      exp_done     <= 1'b0;
      load_pending <= 1'b0;
      exp_q.delete();
    end else begin
      load_pending <= 1'b0;
      if (run_left > 0) begin
        run_left <= run_left - 1;
        exp_done <= (run_left == 1);
      end else begin
        exp_done <= 1'b0;
        if (start) begin
          exp_q.push_back(32'(a) * 32'(b));
          run_left     <= 16;
          load_pending <= 1'b1;
          load_b       <= b;
        end
      end
    end
  end

  // Monitor / scoreboard
  logic [31:0] last_prod = '0;
  logic        last_zero = 1'b0;
  logic        last_ovf  = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_hilo", {hi, lo}, 0);
      chk("rst_zero", zero, 0);
      chk("rst_ovf", ovf, 0);
      last_prod <= '0;
      last_zero <= 1'b0;
      last_ovf  <= 1'b0;
    end else begin
      chk("busy", busy, (run_left > 0));
      chk("done", done, exp_done);
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          chk("product", {hi, lo}, exp_q[0]);
          chk("zero", zero, (exp_q[0] == 0));
          chk("ovf", ovf, (exp_q[0][31:16] != 0));
          last_prod <= exp_q[0];
          last_zero <= (exp_q[0] == 0);
          last_ovf  <= (exp_q[0][31:16] != 0);
          void'(exp_q.pop_front());
        end
      end else if (load_pending) begin
        chk("load_hilo", {hi, lo}, {16'h0, load_b});
      end else if (run_left == 0) begin
        chk("hold_hilo", {hi, lo}, last_prod);
        chk("hold_zero", zero, last_zero);
        chk("hold_ovf", ovf, last_ovf);
      end
    end
  end

  task automatic drive_start(input logic [15:0] av, input logic [15:0] bv);
    @(posedge clk);
    #2;
    start = 1'b1;
    a     = av;
    b     = bv;
    @(posedge clk);
    #2;
    start = 1'b0;
    a     = 16'($urandom);
    b     = 16'($urandom);
  endtask

  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s: no done within 40 cycles (got 0 expected 1)", name);
    end
  endtask

  task automatic rand_op(output logic [15:0] v);
    int sel;
    sel = $urandom_range(0, 9);
    if (sel == 0)      v = 16'h0000;
    else if (sel == 1) v = 16'hFFFF;
    else if (sel == 2) v = 16'h0001;
    else               v = 16'($urandom);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ra, rb;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    drive_start(16'd3, 16'd5);
    wait_done("op_3x5");
    drive_start(16'hFFFF, 16'hFFFF);
    wait_done("op_ffff");
    drive_start(16'h1234, 16'h0000);
    wait_done("op_zero");

    // start held through RUN, operands changed mid-op, chained op from DONE
    @(posedge clk);
    #2;
    start = 1'b1;
    a     = 16'd7;
    b     = 16'd7;
    @(posedge clk);
    repeat (5) @(posedge clk);
    #2;
    a = 16'd9;
    b = 16'd9;
    wait_done("op_7x7");
    @(posedge clk);
    #2 start = 1'b0;
    wait_done("op_9x9");

    // asynchronous reset at iteration 8
    drive_start(16'h00FF, 16'h0100);
    repeat (7) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_done", done, 0);
    chk("async_rst_hilo", {hi, lo}, 0);
    chk("async_rst_flags", {zero, ovf}, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    repeat (20) @(posedge clk);
    drive_start(16'h00FF, 16'h0100);
    wait_done("op_after_rst");

    for (int n = 0; n < 1000; n++) begin
      rand_op(ra);
      rand_op(rb);
      drive_start(ra, rb);
      wait_done("op_random");
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_mul_seq.md
Name: alu_mul_seq

Overview:
- Multi-cycle 16x16 unsigned multiply sequencer built around the shared 16-bit ALU (ADD/SUB/INC/SHL/SHR/AND/ORR/NOT, flags z/n/c).
- Runs shift-add: one ALU ADD per cycle for 16 cycles, producing a 32-bit product {hi, lo}.
- Sits beside the register file in the datapath and serves MUL instructions.
- Uses a start/busy/done handshake toward the control unit.

Parameters:
- WIDTH, 16, operand width. Must equal the ALU width; other values unsupported.
- ITERS, 16, number of shift-add iterations. Must equal WIDTH.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only in IDLE or DONE
- a  in  16  multiplicand, captured when start is accepted
- b  in  16  multiplier, captured when start is accepted
- busy  out  1  high while in RUN
- done  out  1  one-cycle pulse; product valid
- hi  out  16  product bits [31:16]
- lo  out  16  product bits [15:0]
- zero  out  1  product == 0, updated with done
- ovf  out  1  hi != 0 (product does not fit 16 bits), updated with done

Behaviour:
- Reset (async, rst=1): state=IDLE, busy=0, done=0, hi=0, lo=0, zero=0, ovf=0, cnt=0, M=0.
- Internal registers: M (16, multiplicand), P_hi (16), P_lo (16), cnt (4). hi/lo outputs are P_hi/P_lo.
- States:
  - IDLE: start=1 -> capture M=a, P_hi=0, P_lo=b, cnt=0; go to RUN.
  - RUN: one iteration per cycle.
    - ALU driven with func=ADD, a=P_hi, b=(P_lo[0] ? M : 0).
    - Update {P_hi, P_lo} <= {alu.c, alu.r, P_lo} >> 1, i.e. P_hi={c, r[15:1]}, P_lo={r[0], P_lo[15:1]}.
    - cnt++. When cnt==15 at the edge, go to DONE.
  - DONE: done=1 for this cycle; zero and ovf registered on entry.
    - start=1 -> capture operands, go to RUN (back-to-back; no idle gap).
    - else go to IDLE.
- Latency: start accepted at edge k. busy=1 during cycles k+1..k+16. done=1 in cycle k+17.
- Results (hi, lo, zero, ovf) hold until the next accepted start. On accept, hi/lo change to 0/b.
- start in RUN is ignored; operands are not re-captured.
- a/b changes after acceptance have no effect.
- busy and done are never both 1.
- ALU inputs outside RUN: func=ADD, a=0, b=0 (deterministic, no glitch requirement).
- Carry of the ALU ADD is always consumed as bit 15 of the new P_hi; there is no lost carry. The product is exact for all 2^32 operand pairs.
- rst asserted mid-RUN: immediate return to reset values; the partial product is discarded and no done is produced.
- ALU z/n flags are unused by this block.

Decomposition:
- Shared package: ALU func code constants (ADD=000 ... NOT=111), state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2), WIDTH constant.
- One sub-module instance: the existing alu, unmodified. The sequencer holds only FSM, counter and the M/P registers.

Test Plan:
- a=3, b=5, start one cycle -> busy 16 cycles; done in cycle k+17 with hi=0x0000, lo=0x000F, zero=0, ovf=0.
- a=0xFFFF, b=0xFFFF -> hi=0xFFFE, lo=0x0001, ovf=1 (exercises ALU carry every iteration).
- a=0x1234, b=0 -> hi=0, lo=0, zero=1, ovf=0.
- Start held high during RUN with a=7, b=7 changing to a=9, b=9 mid-op -> single done, product 0x0031. Start still high in the DONE cycle -> new op begins at once with a=9, b=9, second done 17 cycles later with lo=0x0051.
- rst pulsed at iteration 8 of a=0x00FF, b=0x0100 -> all outputs return to reset values asynchronously, no done pulse. A fresh start afterwards yields hi=0x0000, lo=0xFF00.
- Random 1000 operand pairs vs reference a*b -> exact {hi, lo}; zero and ovf consistent; done exactly once per accepted start.
